// File: rtl/instruction_issue.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_issue (with package instruction_issue_pkg)
//  Description : Issue stage. Holds the architectural register file and a
//                per-register pending scoreboard. Each cycle it either
//                dispatches the ID instruction to one execution pipe or
//                stalls ID/IFD on a data or structural hazard. A WB redirect
//                flushes the scoreboard and drops the ID instruction.
//
//  Ports
//    clk, rst        : clock, synchronous active-high reset
//    wb_do_branch    : redirect/flush from WB
//    id_valid        : ID presents a valid decoded instruction
//    id_ix_inf       : decoded instruction bundle
//    ix_stall        : combinational hold request to ID/IFD
//    exe_ready[3:0]  : per-pipe accept (ALU, MUL, DIV, LSU)
//    wb_valid/rd/data: writeback port into the register file
//    ix_valid[3:0]   : one-hot dispatch strobe (registered)
//    ix_inf          : dispatched instruction (registered)
//    ix_rs1/2_data   : operand values (registered)
//
//  Revision    : 1.0  initial release
// ============================================================================

package instruction_issue_pkg;

    localparam int EXE_PIPE_ID_ALU = 0;
    localparam int EXE_PIPE_ID_MUL = 1;
    localparam int EXE_PIPE_ID_DIV = 2;
    localparam int EXE_PIPE_ID_LSU = 3;
    localparam int NUM_EXE_PIPES   = 4;

    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              imm_ext;
        logic [7:0]               ctrl;
        logic [NUM_EXE_PIPES-1:0] exe_pipe;
        logic                     register_write;
        logic [4:0]               rd;
        logic [4:0]               a2;
        logic [4:0]               a1;
    } id_ix_inf_t;

endpackage

module instruction_issue
    import instruction_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_do_branch,
    input  logic        id_valid,
    input  id_ix_inf_t  id_ix_inf,
    output logic        ix_stall,
    input  logic [3:0]  exe_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [3:0]  ix_valid,
    output id_ix_inf_t  ix_inf,
    output logic [31:0] ix_rs1_data,
    output logic [31:0] ix_rs2_data
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_regs [0:31];     // entry 0 is never written nor read
    logic [31:0] r_pending;
    logic [3:0]  r_ix_valid;
    id_ix_inf_t  r_ix_inf;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;

    // ------------------------------------------------------------------
    // Writeback decode
    // ------------------------------------------------------------------
    logic        w_wb_wr;
    logic [31:0] w_wb_clr;
    logic [31:0] w_pend_eff;

    assign w_wb_wr  = wb_valid & (wb_rd != 5'd0);
    assign w_wb_clr = w_wb_wr ? (32'd1 << wb_rd) : 32'd0;

    // Pending view after this cycle's WB clear: a consumer waiting on the
    // register being written back can issue now and pick the value up
    // through the write-through read path.
    assign w_pend_eff = r_pending & ~w_wb_clr;

    // ------------------------------------------------------------------
    // Hazard / issue decision
    // ------------------------------------------------------------------
    logic w_hazard;
    logic w_struct;
    logic w_stall;
    logic w_issue;
    logic w_sets_pending;

    assign w_hazard = id_valid & ( w_pend_eff[id_ix_inf.a1]
                                 | w_pend_eff[id_ix_inf.a2]
                                 | (id_ix_inf.register_write & w_pend_eff[id_ix_inf.rd]) );

    assign w_struct = id_valid & (|(id_ix_inf.exe_pipe & ~exe_ready));

    // A redirect overrides any stall since the ID instruction is dropped.
    assign w_stall  = (w_hazard | w_struct) & ~wb_do_branch & ~rst;
    assign w_issue  = id_valid & ~w_stall & ~wb_do_branch & ~rst;

    // A NOP (no target pipe) never produces a result, so it reserves nothing.
    assign w_sets_pending = w_issue & id_ix_inf.register_write
                          & (|id_ix_inf.exe_pipe) & (id_ix_inf.rd != 5'd0);

    assign ix_stall = w_stall;

    // ------------------------------------------------------------------
    // Register file read with write-through
    // ------------------------------------------------------------------
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;

    always_comb begin
        w_rs1_data = 32'd0;
        if (id_ix_inf.a1 != 5'd0) begin
            if (w_wb_wr && (wb_rd == id_ix_inf.a1)) begin
                w_rs1_data = wb_data;
            end else begin
                w_rs1_data = r_regs[id_ix_inf.a1];
            end
        end
    end

    always_comb begin
        w_rs2_data = 32'd0;
        if (id_ix_inf.a2 != 5'd0) begin
            if (w_wb_wr && (wb_rd == id_ix_inf.a2)) begin
                w_rs2_data = wb_data;
            end else begin
                w_rs2_data = r_regs[id_ix_inf.a2];
            end
        end
    end

    // Register file contents are not reset; software initialises them.
    always_ff @(posedge clk) begin
        if (w_wb_wr) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 32'd0;
        end else if (wb_do_branch) begin
            // Nothing issues during a redirect, so no bit can be set here.
            r_pending <= 32'd0;
        end else if (w_sets_pending) begin
            // OR-ing the set after the clear makes set win on a collision.
            r_pending <= (w_pend_eff | (32'd1 << id_ix_inf.rd)) & ~32'd1;
        end else begin
            r_pending <= w_pend_eff & ~32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Dispatch registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ix_valid <= 4'd0;
        end else if (w_issue) begin
            r_ix_valid <= id_ix_inf.exe_pipe;
        end else begin
            r_ix_valid <= 4'd0;
        end
    end

    // Payload is left unreset and simply holds when nothing issues.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_ix_inf   <= id_ix_inf;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
        end
    end

    assign ix_valid    = r_ix_valid;
    assign ix_inf      = r_ix_inf;
    assign ix_rs1_data = r_rs1_data;
    assign ix_rs2_data = r_rs2_data;

endmodule

`default_nettype wire

// File: tb/tb_instruction_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_issue
//  Description : Self-checking bench for instruction_issue. Directed scenario
//                tasks plus a randomized run, all checked against a
//                register/pending-array reference model kept in the bench.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_issue;
    import instruction_issue_pkg::*;

    localparam logic [3:0] P_ALU = 4'b0001;
    localparam logic [3:0] P_MUL = 4'b0010;
    localparam logic [3:0] P_DIV = 4'b0100;
    localparam logic [3:0] P_LSU = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_do_branch = 1'b0;
    logic        id_valid = 1'b0;
    id_ix_inf_t  id_ix_inf = '0;
    logic        ix_stall;
    logic [3:0]  exe_ready = 4'hF;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic [3:0]  ix_valid;
    id_ix_inf_t  ix_inf;
    logic [31:0] ix_rs1_data;
    logic [31:0] ix_rs2_data;

    instruction_issue u_dut (
        .clk          (clk),
        .rst          (rst),
        .wb_do_branch (wb_do_branch),
        .id_valid     (id_valid),
        .id_ix_inf    (id_ix_inf),
        .ix_stall     (ix_stall),
        .exe_ready    (exe_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .ix_valid     (ix_valid),
        .ix_inf       (ix_inf),
        .ix_rs1_data  (ix_rs1_data),
        .ix_rs2_data  (ix_rs2_data)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit          m_pend [32];
    logic [31:0] m_rf   [32];
    logic [3:0]  m_valid = 4'd0;
    id_ix_inf_t  m_inf   = '0;
    logic [31:0] m_rs1   = 32'd0;
    logic [31:0] m_rs2   = 32'd0;
    bit          m_known = 1'b0;
    bit          m_stall = 1'b0;
    bit          m_issue = 1'b0;
    logic        s_stall;

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_valid && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 5'd0) && m_pend[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic id_ix_inf_t mk(input logic [4:0] a1, input logic [4:0] a2,
                                      input logic [4:0] rd, input logic rw,
                                      input logic [3:0] pipe);
        id_ix_inf_t t;
        t.a1             = a1;
        t.a2             = a2;
        t.rd             = rd;
        t.register_write = rw;
        t.exe_pipe       = pipe;
        t.imm_ext        = $urandom;
        t.pc             = $urandom;
        t.ctrl           = 8'($urandom);
        return t;
    endfunction

    // One clock cycle: sample the stall and evaluate the model mid-cycle,
    // then advance the model on the edge. Inputs change only after return.
    task automatic tick();
        bit hz;
        bit st;
        @(negedge clk);
        hz = id_valid && (m_busy(id_ix_inf.a1) || m_busy(id_ix_inf.a2) ||
                          (id_ix_inf.register_write && m_busy(id_ix_inf.rd)));
        st = 1'b0;
        for (int p = 0; p < 4; p++)
            if (id_valid && id_ix_inf.exe_pipe[p] && !exe_ready[p]) st = 1'b1;
        m_stall = !rst && !wb_do_branch && (hz || st);
        m_issue = !rst && !wb_do_branch && id_valid && !m_stall;
        s_stall = ix_stall;
        @(posedge clk);
        if (rst) begin
            m_valid = 4'd0;
            for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        end else begin
            if (m_issue) begin
                m_valid = id_ix_inf.exe_pipe;
                m_inf   = id_ix_inf;
                m_rs1   = m_read(id_ix_inf.a1);
                m_rs2   = m_read(id_ix_inf.a2);
                m_known = 1'b1;
            end else begin
                m_valid = 4'd0;
            end
            if (wb_valid && wb_rd != 5'd0) m_pend[wb_rd] = 1'b0;
            if (wb_do_branch)
                for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
            if (m_issue && id_ix_inf.register_write && id_ix_inf.rd != 5'd0 &&
                id_ix_inf.exe_pipe != 4'd0)
                m_pend[id_ix_inf.rd] = 1'b1;
        end
        if (wb_valid && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
        #1;
    endtask

    task automatic idle();
        rst          = 1'b0;
        wb_do_branch = 1'b0;
        id_valid     = 1'b0;
        exe_ready    = 4'hF;
        wb_valid     = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = 32'd0;
    endtask

    task automatic retire(input logic [4:0] r);
        idle();
        wb_valid = 1'b1;
        wb_rd    = r;
        wb_data  = $urandom;
        tick();
        idle();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        id_valid  = 1'b1;
        id_ix_inf = mk(5'd1, 5'd2, 5'd3, 1'b1, P_ALU);
        exe_ready = 4'h0;
        tick();
        n_cmp++;
        if (s_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", s_stall);
        end
        tick();
        n_cmp++;
        if (ix_valid !== 4'd0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0000", ix_valid);
        end
        idle();
    endtask

    task automatic test_init_regs();
        for (int r = 1; r < 32; r++) begin
            wb_valid = 1'b1;
            wb_rd    = 5'(r);
            wb_data  = $urandom;
            tick();
        end
        idle();
        tick();
        n_cmp++;
        if (ix_valid !== 4'd0) begin
            n_fail++; $display("FAIL init_valid: got %b want 0000", ix_valid);
        end
    endtask

    task automatic test_write_through();
        id_ix_inf_t ins;
        ins       = mk(5'd5, 5'd0, 5'd6, 1'b1, P_ALU);
        wb_valid  = 1'b1;
        wb_rd     = 5'd5;
        wb_data   = 32'h1234;
        id_valid  = 1'b1;
        id_ix_inf = ins;
        tick();
        n_cmp++;
        if (s_stall !== 1'b0) begin
            n_fail++; $display("FAIL wt_stall: got %b want 0", s_stall);
        end
        n_cmp++;
        if (ix_valid !== P_ALU || ix_rs1_data !== 32'h1234 || ix_rs2_data !== 32'd0) begin
            n_fail++;
            $display("FAIL wt_issue: got v=%b rs1=%h rs2=%h want v=0001 rs1=00001234 rs2=0",
                     ix_valid, ix_rs1_data, ix_rs2_data);
        end
        n_cmp++;
        if (ix_inf !== ins) begin
            n_fail++; $display("FAIL wt_inf: got %h want %h", ix_inf, ins);
        end
        retire(5'd6);
        n_cmp++;
        if (ix_valid !== 4'd0 || ix_rs1_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL wt_hold: got v=%b rs1=%h want v=0000 rs1=00001234",
                     ix_valid, ix_rs1_data);
        end
    endtask

    task automatic test_raw_stall();
        logic [31:0] d;
        idle();
        id_valid  = 1'b1;
        id_ix_inf = mk(5'd1, 5'd0, 5'd7, 1'b1, P_LSU);
        tick();
        n_cmp++;
        if (ix_valid !== P_LSU) begin
            n_fail++; $display("FAIL raw_producer: got %b want 1000", ix_valid);
        end
        id_ix_inf = mk(5'd7, 5'd7, 5'd8, 1'b1, P_ALU);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (s_stall !== 1'b1 || ix_valid !== 4'd0) begin
                n_fail++;
                $display("FAIL raw_wait%0d: got stall=%b v=%b want stall=1 v=0000",
                         i, s_stall, ix_valid);
            end
        end
        d        = $urandom;
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        wb_data  = d;
        tick();
        n_cmp++;
        if (s_stall !== 1'b0 || ix_valid !== P_ALU) begin
            n_fail++;
            $display("FAIL raw_release: got stall=%b v=%b want stall=0 v=0001", s_stall, ix_valid);
        end
        n_cmp++;
        if (ix_rs1_data !== d || ix_rs2_data !== d) begin
            n_fail++;
            $display("FAIL raw_operands: got %h/%h want %h/%h", ix_rs1_data, ix_rs2_data, d, d);
        end
        retire(5'd8);
    endtask

    task automatic test_structural();
        int cnt;
        idle();
        cnt       = 0;
        id_valid  = 1'b1;
        id_ix_inf = mk(5'd1, 5'd2, 5'd12, 1'b1, P_DIV);
        exe_ready = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (s_stall === 1'b1) cnt++;
            n_cmp++;
            if (ix_valid !== 4'd0) begin
                n_fail++; $display("FAIL struct_hold%0d: got %b want 0000", i, ix_valid);
            end
        end
        n_cmp++;
        if (cnt != 3) begin
            n_fail++; $display("FAIL struct_count: got %0d want 3", cnt);
        end
        exe_ready = 4'hF;
        tick();
        n_cmp++;
        if (s_stall !== 1'b0 || ix_valid !== P_DIV) begin
            n_fail++;
            $display("FAIL struct_issue: got stall=%b v=%b want stall=0 v=0100", s_stall, ix_valid);
        end
        retire(5'd12);
        n_cmp++;
        if (ix_valid !== 4'd0) begin
            n_fail++; $display("FAIL struct_single: got %b want 0000", ix_valid);
        end
    endtask

    task automatic test_flush();
        idle();
        id_valid  = 1'b1;
        id_ix_inf = mk(5'd0, 5'd0, 5'd3, 1'b1, P_LSU);
        tick();
        id_ix_inf = mk(5'd3, 5'd0, 5'd4, 1'b1, P_ALU);
        tick();
        n_cmp++;
        if (s_stall !== 1'b1) begin
            n_fail++; $display("FAIL flush_pre_stall: got %b want 1", s_stall);
        end
        wb_do_branch = 1'b1;
        tick();
        n_cmp++;
        if (s_stall !== 1'b0 || ix_valid !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_drop: got stall=%b v=%b want stall=0 v=0000", s_stall, ix_valid);
        end
        wb_do_branch = 1'b0;
        tick();
        n_cmp++;
        if (s_stall !== 1'b0 || ix_valid !== P_ALU || ix_rs1_data !== m_rs1) begin
            n_fail++;
            $display("FAIL flush_after: got stall=%b v=%b rs1=%h want stall=0 v=0001 rs1=%h",
                     s_stall, ix_valid, ix_rs1_data, m_rs1);
        end
        retire(5'd4);
    endtask

    task automatic test_x0();
        idle();
        id_valid  = 1'b1;
        id_ix_inf = mk(5'd0, 5'd0, 5'd0, 1'b1, P_ALU);
        id_ix_inf.imm_ext = 32'd5;
        tick();
        n_cmp++;
        if (ix_valid !== P_ALU || ix_rs1_data !== 32'd0) begin
            n_fail++; $display("FAIL x0_addi: got v=%b rs1=%h want v=0001 rs1=0", ix_valid, ix_rs1_data);
        end
        wb_valid  = 1'b1;
        wb_rd     = 5'd0;
        wb_data   = 32'd5;
        id_ix_inf = mk(5'd0, 5'd0, 5'd1, 1'b1, P_ALU);
        tick();
        n_cmp++;
        if (s_stall !== 1'b0 || ix_rs1_data !== 32'd0 || ix_rs2_data !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_read_wb: got stall=%b rs1=%h rs2=%h want stall=0 rs1=0 rs2=0",
                     s_stall, ix_rs1_data, ix_rs2_data);
        end
        wb_valid  = 1'b0;
        id_ix_inf = mk(5'd0, 5'd0, 5'd2, 1'b1, P_ALU);
        tick();
        n_cmp++;
        if (s_stall !== 1'b0 || ix_rs1_data !== 32'd0) begin
            n_fail++; $display("FAIL x0_read: got stall=%b rs1=%h want stall=0 rs1=0", s_stall, ix_rs1_data);
        end
        retire(5'd1);
        retire(5'd2);
    endtask

    task automatic test_collision();
        idle();
        id_valid  = 1'b1;
        id_ix_inf = mk(5'd0, 5'd0, 5'd9, 1'b1, P_LSU);
        tick();
        wb_valid  = 1'b1;
        wb_rd     = 5'd9;
        wb_data   = $urandom;
        id_ix_inf = mk(5'd0, 5'd0, 5'd9, 1'b1, P_LSU);
        tick();
        n_cmp++;
        if (s_stall !== 1'b0 || ix_valid !== P_LSU) begin
            n_fail++;
            $display("FAIL coll_issue: got stall=%b v=%b want stall=0 v=1000", s_stall, ix_valid);
        end
        wb_valid  = 1'b0;
        id_ix_inf = mk(5'd9, 5'd0, 5'd10, 1'b1, P_ALU);
        tick();
        n_cmp++;
        if (s_stall !== 1'b1) begin
            n_fail++; $display("FAIL coll_pending: got stall=%b want 1", s_stall);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        wb_data  = $urandom;
        tick();
        n_cmp++;
        if (s_stall !== 1'b0 || ix_valid !== P_ALU) begin
            n_fail++;
            $display("FAIL coll_release: got stall=%b v=%b want stall=0 v=0001", s_stall, ix_valid);
        end
        retire(5'd10);
    endtask

    task automatic test_nop();
        id_ix_inf_t ins;
        idle();
        ins       = mk(5'd0, 5'd0, 5'd11, 1'b1, 4'd0);
        id_valid  = 1'b1;
        id_ix_inf = ins;
        tick();
        n_cmp++;
        if (s_stall !== 1'b0 || ix_valid !== 4'd0 || ix_inf !== ins) begin
            n_fail++;
            $display("FAIL nop_issue: got stall=%b v=%b inf=%h want stall=0 v=0000 inf=%h",
                     s_stall, ix_valid, ix_inf, ins);
        end
        id_ix_inf = mk(5'd11, 5'd11, 5'd13, 1'b1, P_MUL);
        tick();
        n_cmp++;
        if (s_stall !== 1'b0 || ix_valid !== P_MUL) begin
            n_fail++;
            $display("FAIL nop_no_pending: got stall=%b v=%b want stall=0 v=0010", s_stall, ix_valid);
        end
        retire(5'd13);
    endtask

    task automatic test_random();
        logic [3:0] pipe;
        logic [4:0] pick;
        idle();
        for (int cyc = 0; cyc < 600; cyc++) begin
            // ID holds its instruction while stalled
            if (!(id_valid && m_stall)) begin
                id_valid = ($urandom_range(0, 3) != 0);
                pipe     = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'(1 << $urandom_range(0, 3));
                id_ix_inf = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pipe);
            end
            exe_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            wb_valid  = 1'($urandom_range(0, 1));
            pick      = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 7)
                for (int r = 1; r < 8; r++) if (m_pend[r]) pick = 5'(r);
            wb_rd        = pick;
            wb_data      = $urandom;
            wb_do_branch = ($urandom_range(0, 19) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            tick();
            n_cmp++;
            if (s_stall !== m_stall) begin
                n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, s_stall, m_stall);
            end
            n_cmp++;
            if (ix_valid !== m_valid || !$onehot0(ix_valid)) begin
                n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, ix_valid, m_valid);
            end
            if (m_known) begin
                n_cmp++;
                if (ix_inf !== m_inf || ix_rs1_data !== m_rs1 || ix_rs2_data !== m_rs2) begin
                    n_fail++;
                    $display("FAIL rnd_payload c%0d: got %h %h %h want %h %h %h", cyc,
                             ix_inf, ix_rs1_data, ix_rs2_data, m_inf, m_rs1, m_rs2);
                end
            end
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_pend[r] = 1'b0;
            m_rf[r]   = 32'd0;
        end
        test_reset();
        test_init_regs();
        test_write_through();
        test_raw_stall();
        test_structural();
        test_flush();
        test_x0();
        test_collision();
        test_nop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
